fb_write_scheduler: RTL and testbench

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

---
 rtl/fb_write_scheduler.sv | 145 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// Double-buffered framebuffer write scheduler: clears the back buffer, forwards draw writes, swaps on frame_pulse.
// Optional FB_OVERRUN_COUNT_EN adds a saturating 16-bit overrun_count output.
module fb_write_scheduler #(
   parameter  int SCREEN_WIDTH  = 640,
   parameter  int SCREEN_HEIGHT = 480,
   localparam int N             = SCREEN_WIDTH * SCREEN_HEIGHT,
   localparam int AW            = $clog2(N)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          frame_pulse,
   input  logic          draw_valid,
   input  logic [AW-1:0] draw_addr,
   input  logic          draw_data,
   output logic          draw_ready,
   input  logic          draw_done,
   output logic          fb_wr_en,
   output logic [AW-1:0] fb_wr_addr,
   output logic          fb_wr_data,
   output logic          fb_wr_sel,
   output logic          front_sel,
`ifdef FB_OVERRUN_COUNT_EN
   output logic [15:0]   overrun_count,
`endif
   output logic          overrun
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] N_CNT = CW'(N);

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, WAIT_SWAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
   logic            front_q, front_d;
   logic            wr_sel_q;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic            wr_data_q, wr_data_d;
   logic            overrun_q, overrun_d;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      front_d   = front_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      overrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
         end
         CLEAR: begin
            // Counter runs one past N-1 so DRAW starts after the last clear write is visible.
            if (clr_cnt_q < N_CNT) begin
               wr_en_d   = 1'b1;
               wr_addr_d = clr_cnt_q[AW-1:0];
               wr_data_d = 1'b0;
               clr_cnt_d = clr_cnt_q + CW'(1);
            end else begin
               state_d = DRAW;
            end
            overrun_d = frame_pulse;
         end
         DRAW: begin
            if (draw_valid) begin
               wr_addr_d = draw_addr;
               wr_data_d = draw_data;
               wr_en_d   = ({1'b0, draw_addr} < N_CNT);
            end
            if (draw_done && frame_pulse) begin
               front_d   = ~front_q;
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end else if (draw_done) begin
               state_d = WAIT_SWAP;
            end else begin
               overrun_d = frame_pulse;
            end
         end
         WAIT_SWAP: begin
            if (frame_pulse) begin
               front_d   = ~front_q;
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         front_q   <= 1'b0;
         wr_sel_q  <= 1'b1;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         front_q   <= front_d;
         wr_sel_q  <= ~front_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef FB_OVERRUN_COUNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
         ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`endif

   assign draw_ready = (state_q == DRAW);
   assign fb_wr_en   = wr_en_q;
   assign fb_wr_addr = wr_addr_q;
   assign fb_wr_data = wr_data_q;
   assign fb_wr_sel  = wr_sel_q;
   assign front_sel  = front_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler (8x4 main instance, 5x6 instance for out-of-range addresses).
// A queue-based reference model is compared against the main instance every cycle.
module tb_fb_write_scheduler;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int NB = 30;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       frame_pulse = 1'b0;
   logic       draw_valid = 1'b0;
   logic [4:0] draw_addr = '0;
   logic       draw_data = 1'b0;
   logic       draw_done = 1'b0;
   logic       draw_ready, fb_wr_en, fb_wr_data, fb_wr_sel, front_sel, overrun;
   logic [4:0] fb_wr_addr;
`ifdef FB_OVERRUN_COUNT_EN
   logic [15:0] overrun_count;
   logic [15:0] overrun_count_b;
`endif

   logic       resetn_b = 1'b0;
   logic       draw_valid_b = 1'b0;
   logic [4:0] draw_addr_b = '0;
   logic       draw_data_b = 1'b0;
   logic       zero_b = 1'b0;
   logic       draw_ready_b, fb_wr_en_b, fb_wr_data_b, fb_wr_sel_b, front_sel_b, overrun_b;
   logic [4:0] fb_wr_addr_b;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   fb_write_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
      .clk(clk), .resetn(resetn), .frame_pulse(frame_pulse),
      .draw_valid(draw_valid), .draw_addr(draw_addr), .draw_data(draw_data),
      .draw_ready(draw_ready), .draw_done(draw_done),
      .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
      .fb_wr_sel(fb_wr_sel), .front_sel(front_sel),
`ifdef FB_OVERRUN_COUNT_EN
      .overrun_count(overrun_count),
`endif
      .overrun(overrun)
   );

   fb_write_scheduler #(.SCREEN_WIDTH(5), .SCREEN_HEIGHT(6)) dut_b (
      .clk(clk), .resetn(resetn_b), .frame_pulse(zero_b),
      .draw_valid(draw_valid_b), .draw_addr(draw_addr_b), .draw_data(draw_data_b),
      .draw_ready(draw_ready_b), .draw_done(zero_b),
      .fb_wr_en(fb_wr_en_b), .fb_wr_addr(fb_wr_addr_b), .fb_wr_data(fb_wr_data_b),
      .fb_wr_sel(fb_wr_sel_b), .front_sel(front_sel_b),
`ifdef FB_OVERRUN_COUNT_EN
      .overrun_count(overrun_count_b),
`endif
      .overrun(overrun_b)
   );

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_CLEAR = 1, M_DRAW = 2, M_WAIT = 3;
   int   m_mode = M_IDLE;
   int   clr_queue[$];
   bit   e_wr = 0, e_data = 0, e_front = 0, e_ov = 0;
   int   e_addr = 0;
   int   e_cnt = 0;

   function automatic void start_clear();
      clr_queue.delete();
      for (int i = 0; i < N; i++) clr_queue.push_back(i);
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_mode = M_IDLE; clr_queue.delete();
         e_wr = 0; e_addr = 0; e_data = 0; e_front = 0; e_ov = 0; e_cnt = 0;
      end else begin
         e_wr = 0;
         e_ov = 0;
         case (m_mode)
            M_IDLE: begin m_mode = M_CLEAR; start_clear(); end
            M_CLEAR: begin
               if (clr_queue.size() > 0) begin
                  e_wr = 1; e_addr = clr_queue.pop_front(); e_data = 0;
               end else m_mode = M_DRAW;
               e_ov = frame_pulse;
            end
            M_DRAW: begin
               if (draw_valid) begin
                  e_addr = int'(draw_addr); e_data = draw_data;
                  e_wr = (int'(draw_addr) < N);
               end
               if (draw_done && frame_pulse) begin
                  e_front = !e_front; m_mode = M_CLEAR; start_clear();
               end else if (draw_done) m_mode = M_WAIT;
               else e_ov = frame_pulse;
            end
            default: begin
               if (frame_pulse) begin
                  e_front = !e_front; m_mode = M_CLEAR; start_clear();
               end
            end
         endcase
         if (e_ov && e_cnt < 65535) e_cnt++;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         bit bad;
         int act_cnt;
         act_cnt = e_cnt;
`ifdef FB_OVERRUN_COUNT_EN
         act_cnt = int'(overrun_count);
`endif
         bad = (fb_wr_en !== e_wr) || (front_sel !== e_front) || (fb_wr_sel !== !e_front)
               || (overrun !== e_ov) || (draw_ready !== (m_mode == M_DRAW)) || (act_cnt != e_cnt);
         if (e_wr && ((int'(fb_wr_addr) != e_addr) || (fb_wr_data !== e_data))) bad = 1;
         vectors++;
         if (bad) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t: got wr_en=%b addr=%0d data=%b sel=%b front=%b ovr=%b rdy=%b cnt=%0d; expected wr_en=%b addr=%0d data=%b sel=%b front=%b ovr=%b rdy=%b cnt=%0d",
                     $time, fb_wr_en, fb_wr_addr, fb_wr_data, fb_wr_sel, front_sel, overrun, draw_ready, act_cnt,
                     e_wr, e_addr, e_data, !e_front, e_front, e_ov, (m_mode == M_DRAW), e_cnt);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end else begin
         $display("ok   %s = %0d", nm, act);
      end
   endtask

   task automatic wait_ready(input string nm, output int cycles);
      cycles = 0;
      while (!draw_ready && cycles < 60) begin tick(); cycles++; end
      chk(nm, int'(draw_ready), 1);
   endtask

   task automatic clear_from_release();
      int k;
      repeat (2) tick();
      chk("clr_first_en", int'(fb_wr_en), 1);
      chk("clr_first_addr", int'(fb_wr_addr), 0);
      chk("clr_wr_sel", int'(fb_wr_sel), ~int'(front_sel) & 1);
      repeat (31) tick();
      chk("clr_last_addr", int'(fb_wr_addr), N - 1);
      chk("clr_last_rdy", int'(draw_ready), 0);
      tick();
      chk("draw_rdy_c34", int'(draw_ready), 1);
      chk("draw_idle_wr", int'(fb_wr_en), 0);
   endtask

   initial begin
      int k;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_front", int'(front_sel), 0);
      chk("rst_wr_en", int'(fb_wr_en), 0);
      chk("rst_ready", int'(draw_ready), 0);
      resetn = 1'b1;
      clear_from_release();

      // Burst of three consecutive writes
      draw_valid = 1; draw_data = 1; draw_addr = 5'd5; tick();
      draw_addr = 5'd6; tick();
      draw_addr = 5'd7; tick();
      chk("burst_addr7", int'(fb_wr_addr), 7);
      chk("burst_data", int'(fb_wr_data), 1);
      draw_addr = 5'd31; draw_data = 0; tick();
      draw_valid = 0;
      chk("max_addr_en", int'(fb_wr_en), 1);
      chk("max_addr", int'(fb_wr_addr), 31);

      // Overrun while drawing
      frame_pulse = 1; tick(); frame_pulse = 0;
      chk("draw_ovr", int'(overrun), 1);
      chk("draw_ovr_front", int'(front_sel), 0);
      tick();
      chk("ovr_one_cycle", int'(overrun), 0);

      // draw_done, then frame_pulse ten cycles later
      draw_done = 1; tick(); draw_done = 0;
      draw_valid = 1; draw_addr = 5'd2;
      repeat (9) tick();
      draw_valid = 0;
      frame_pulse = 1; tick(); frame_pulse = 0;
      chk("swap1_front", int'(front_sel), 1);
      chk("swap1_sel", int'(fb_wr_sel), 0);
      tick();
      chk("reclear_addr0", int'(fb_wr_addr), 0);

      // frame_pulse at clear address 10
      k = 0;
      while (fb_wr_addr != 5'd9 && k < 40) begin tick(); k++; end
      frame_pulse = 1; tick(); frame_pulse = 0;
      chk("clr_ovr_addr10", int'(fb_wr_addr), 10);
      chk("clr_ovr", int'(overrun), 1);
      chk("clr_ovr_front", int'(front_sel), 1);
`ifdef FB_OVERRUN_COUNT_EN
      chk("ovr_count", int'(overrun_count), 2);
`endif
      wait_ready("ready_after_reclear", k);

      // draw_done + frame_pulse + transfer in one cycle
      draw_valid = 1; draw_addr = 5'd3; draw_data = 1; draw_done = 1; frame_pulse = 1;
      tick();
      draw_valid = 0; draw_done = 0; frame_pulse = 0;
      chk("same_cyc_front", int'(front_sel), 0);
      chk("same_cyc_ovr", int'(overrun), 0);
      chk("same_cyc_wr_addr", int'(fb_wr_addr), 3);
      chk("same_cyc_wr_en", int'(fb_wr_en), 1);
      tick();
      chk("same_cyc_clr0", int'(fb_wr_addr), 0);
      wait_ready("ready_after_swap2", k);

      // Another swap so a mid-DRAW reset has something to restore
      draw_done = 1; tick(); draw_done = 0;
      frame_pulse = 1; tick(); frame_pulse = 0;
      chk("swap3_front", int'(front_sel), 1);
      wait_ready("ready_after_swap3", k);
      draw_valid = 1; draw_addr = 5'd12; draw_data = 1; tick(); tick();
      draw_valid = 0;
      resetn = 1'b0;
      #1;
      chk("midreset_front", int'(front_sel), 0);
      chk("midreset_ready", int'(draw_ready), 0);
      chk("midreset_wr_en", int'(fb_wr_en), 0);
      tick();
      resetn = 1'b1;
      clear_from_release();

      // Out-of-range addresses on the 30-pixel instance
      resetn_b = 1'b1;
      k = 0;
      while (!draw_ready_b && k < 60) begin tick(); k++; end
      chk("b_ready_cycle", k, 32);
      draw_valid_b = 1; draw_data_b = 1; draw_addr_b = 5'd30; tick();
      chk("b_oor30_rdy", int'(draw_ready_b), 1);
      chk("b_oor30_en", int'(fb_wr_en_b), 0);
      draw_addr_b = 5'd31; tick();
      chk("b_oor31_en", int'(fb_wr_en_b), 0);
      draw_addr_b = 5'd29; tick();
      draw_valid_b = 0;
      chk("b_last_en", int'(fb_wr_en_b), 1);
      chk("b_last_addr", int'(fb_wr_addr_b), 29);
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
